// File: rtl/ntt_poly_io.sv
// rtl/ntt_poly_io.sv - host load/unload controller for the NTT/INTT core.
// Loads one polynomial into coefficient RAM, launches the core, then drains results to a stream.
module ntt_poly_io #(
  parameter int N_COEFF      = 256,
  parameter int WIDTH_ADDR   = 8,
  parameter int WIDTH        = 32,
  parameter int Q            = 3329,
  parameter int START_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_ntt_in,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  ram_sel,
  output logic                  ram_we,
  output logic [WIDTH_ADDR-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata,
  output logic                  core_start,
  output logic                  core_is_ntt,
  input  logic                  core_done_store,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DRAIN} state_t;

  localparam logic [WIDTH_ADDR-1:0] LAST      = WIDTH_ADDR'(N_COEFF - 1);
  localparam logic [7:0]            KICK_LAST = 8'(START_CYCLES - 1);
  localparam logic [11:0]           Q12       = 12'(Q);

  state_t                state;
  logic [WIDTH_ADDR-1:0] cnt;
  logic [WIDTH_ADDR:0]   rd_cnt;
  logic [WIDTH_ADDR-1:0] out_cnt;
  logic [7:0]            kick_cnt;
  logic                  in_flight;
  logic [WIDTH-1:0]      fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;

  logic                  loading;
  logic                  s_fire;
  logic                  m_fire;
  logic                  issue;
  logic [2:0]            occ_eff;
  logic [11:0]           coeff;

  always_comb begin
    loading   = (state == S_IDLE) || (state == S_LOAD);
    s_ready   = rst_n && loading;
    ram_sel   = rst_n && (loading || (state == S_DRAIN));
    s_fire    = s_valid && s_ready;
    ram_we    = s_fire;
    coeff     = s_data[11:0];
    if (coeff >= Q12) coeff = coeff - Q12;
    ram_wdata = {{(WIDTH-12){1'b0}}, coeff};
    m_valid   = (occ != 2'd0);
    m_data    = fifo[rd_ptr];
    m_last    = m_valid && (out_cnt == LAST);
    m_fire    = m_valid && m_ready;
    done      = m_fire && m_last;
    // Credit the beat leaving this cycle so a full-rate drain keeps one read in flight.
    occ_eff   = {1'b0, occ} + {2'b0, in_flight} - {2'b0, m_fire};
    issue     = (state == S_DRAIN) && !rd_cnt[WIDTH_ADDR] && (occ_eff < 3'd2);
    ram_addr  = (state == S_DRAIN) ? rd_cnt[WIDTH_ADDR-1:0] : cnt;
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rd_cnt      <= '0;
      out_cnt     <= '0;
      kick_cnt    <= '0;
      core_start  <= 1'b0;
      core_is_ntt <= 1'b0;
      in_flight   <= 1'b0;
      occ         <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
    end else begin
      in_flight <= issue;
      if (issue) rd_cnt <= rd_cnt + 1'b1;
      if (in_flight) begin
        fifo[wr_ptr] <= ram_rdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (m_fire) begin
        rd_ptr  <= ~rd_ptr;
        out_cnt <= out_cnt + 1'b1;
      end
      occ <= occ + {1'b0, in_flight} - {1'b0, m_fire};

      case (state)
        S_IDLE: begin
          if (s_fire) begin
            core_is_ntt <= is_ntt_in;
            cnt         <= 1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (s_fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              cnt        <= '0;
              kick_cnt   <= '0;
              core_start <= 1'b1;
              state      <= S_KICK;
            end
          end
        end
        S_KICK: begin
          kick_cnt <= kick_cnt + 8'd1;
          if (kick_cnt == KICK_LAST) begin
            core_start <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done_store) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_poly_io.sv
// tb/tb_ntt_poly_io.sv - randomized bench for ntt_poly_io with RAM/core model and scoreboard.
module tb_ntt_poly_io;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_ntt_in;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        ram_sel;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        core_start;
  logic        core_is_ntt;
  logic        core_done_store;
  logic        busy;
  logic        done;

  logic        done_model = 1'b0;
  logic        spurious;
  assign core_done_store = done_model | spurious;

  always #5 clk = ~clk;

  ntt_poly_io dut (
    .clk(clk), .rst_n(rst_n), .is_ntt_in(is_ntt_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .core_start(core_start), .core_is_ntt(core_is_ntt),
    .core_done_store(core_done_store), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  // Stand-in core: tags each word with its address (NTT) or a marker (INTT).
  function automatic logic [31:0] core_fn(input int i, input logic [31:0] v, input logic dir);
    logic [15:0] lo;
    lo = dir ? 16'(i * 7) : 16'hBEEF;
    return {v[15:0], lo};
  endfunction

  logic [31:0] mem [N];
  int          timer;
  logic        core_start_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      timer        <= 0;
      done_model   <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      done_model   <= 1'b0;
      core_start_q <= core_start;
      if (core_start && !core_start_q) timer <= 100;
      else if (timer != 0) begin
        timer <= timer - 1;
        if (timer == 1) begin
          for (int i = 0; i < N; i++) mem[i] <= core_fn(i, mem[i], core_is_ntt);
          done_model <= 1'b1;
        end
      end
      if (ram_sel && ram_we) mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  logic [31:0] exp_out [N];
  logic [31:0] lit_in  [4];
  logic [31:0] lit_exp [4];
  bit          exp_dir, full_ready, pin_lit, pin_zero, cont_load;
  int          jobs_done = 0;

  int          phase = 0, ld_idx = 0, post_cnt = 0, out_idx = 0, age = 0, cyc = 0, first_we = 0;
  bit          in_drain = 0, seen_mv = 0, prev_mv = 0, prev_mr = 0, prev_ml = 0, hs;
  logic [31:0] prev_md;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chkb("rst_s_ready", s_ready, 1'b0);
      chkb("rst_ram_sel", ram_sel, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_m_valid", m_valid, 1'b0);
      chkb("rst_core_start", core_start, 1'b0);
      chkb("rst_ram_we", ram_we, 1'b0);
      chkb("rst_done", done, 1'b0);
      chkb("rst_core_is_ntt", core_is_ntt, 1'b0);
      phase = 0; ld_idx = 0; post_cnt = 0; out_idx = 0; in_drain = 0; prev_mv = 0;
    end else begin
      hs = (phase == 0) && s_valid && s_ready;
      chkb("s_ready", s_ready, phase == 0);
      chkb("ram_sel", ram_sel, (phase == 0) || in_drain);
      chkb("busy", busy, (phase == 1) || (ld_idx != 0));
      chkb("core_start", core_start, (phase == 1) && !in_drain && (post_cnt < 2));
      chkb("ram_we", ram_we, (phase == 0) && s_valid);
      chkb("we_without_owner", ram_we && !ram_sel, 1'b0);
      if (core_start) chkb("core_is_ntt", core_is_ntt, exp_dir);
      if (hs) begin
        chk("ram_addr", 32'(ram_addr), 32'(ld_idx));
        chk("ram_wdata", ram_wdata, 32'(s_data[11:0]) % 32'd3329);
        if (pin_lit && ld_idx < 4) chk("lit_wdata", ram_wdata, lit_exp[ld_idx]);
        if (ld_idx == 0) first_we = cyc;
        if (ld_idx == N - 1 && cont_load) chk("load_span", 32'(cyc - first_we), 32'd255);
      end
      if (!in_drain) begin
        chkb("m_valid_outside_drain", m_valid, 1'b0);
        chkb("done_outside_drain", done, 1'b0);
      end else begin
        if (prev_mv && !prev_mr) begin
          chkb("stall_valid", m_valid, 1'b1);
          chk("stall_data", m_data, prev_md);
          chkb("stall_last", m_last, prev_ml);
        end
        if (m_valid && !seen_mv) begin
          chk("first_valid_latency", 32'(age), 32'd2);
          seen_mv = 1;
        end
        if (full_ready && age >= 2 && age <= 257) chkb("full_rate_valid", m_valid, 1'b1);
        if (m_valid) chkb("m_last", m_last, out_idx == N - 1);
        chkb("done", done, m_valid && m_ready && (out_idx == N - 1));
        if (m_valid && m_ready) begin
          chk("m_data", m_data, exp_out[out_idx]);
          if (pin_zero && out_idx == 10) chk("pin_beat10", m_data, 32'd70);
          if (pin_zero && out_idx == 255) chk("pin_beat255", m_data, 32'd1785);
          if (full_ready && out_idx == N - 1) chk("drain_span", 32'(age), 32'd257);
        end
      end

      prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data; prev_ml = m_last;
      if (in_drain) begin
        age++;
        if (m_valid && m_ready) begin
          out_idx++;
          if (out_idx == N) begin
            in_drain = 0; phase = 0; out_idx = 0; jobs_done++;
          end
        end
      end else if (phase == 1) begin
        if (post_cnt >= 2 && core_done_store) begin
          in_drain = 1; age = 0; seen_mv = 0; prev_mv = 0;
        end
        post_cnt++;
      end else if (hs) begin
        ld_idx++;
        if (ld_idx == N) begin
          phase = 1; ld_idx = 0; post_cnt = 0;
        end
      end
    end
  end

  task automatic run_job(input bit dir, input int kind, input bit gaps, input bit rnd_ready,
                         input bit spur, input int abort_at);
    logic [31:0] d;
    int          c;
    bit          got;
    exp_dir = dir; full_ready = !rnd_ready; pin_lit = (kind == 3);
    pin_zero = (kind == 2); cont_load = !gaps;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          s_valid = 1'b0;
          is_ntt_in = ~dir;
          spurious = spur && ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
        end
      end
      case (kind)
        0: d = $urandom;
        1: d = 32'(i);
        2: d = 32'd0;
        default: d = (i < 4) ? lit_in[i] : $urandom;
      endcase
      c = int'(d[11:0]) % 3329;
      exp_out[i] = core_fn(i, 32'(c), dir);
      if (i == abort_at) begin
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chkb("async_rst_busy", busy, 1'b0);
        chkb("async_rst_s_ready", s_ready, 1'b0);
        chkb("async_rst_ram_sel", ram_sel, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chkb("rst_release_s_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        return;
      end
      s_valid = 1'b1;
      s_data = d;
      is_ntt_in = (i == 0) ? dir : 1'($urandom);
      spurious = spur && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data = $urandom;
    spurious = spur;
    @(posedge clk); #1;
    @(posedge clk); #1;
    spurious = 1'b0;
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (!rnd_ready) m_ready = 1'b1;
      else if (k >= 150 && k < 160) m_ready = 1'b0;
      else m_ready = 1'($urandom);
      @(negedge clk);
      if (done) got = 1;
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    chkb("job_completed", got, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; is_ntt_in = 1'b0; m_ready = 1'b0; spurious = 1'b0;
    lit_in[0] = 32'hFFFF_0D00; lit_in[1] = 32'h1234_0D01;
    lit_in[2] = 32'h0000_0FFF; lit_in[3] = 32'hABCD_E000;
    lit_exp[0] = 32'd3328; lit_exp[1] = 32'd0; lit_exp[2] = 32'd766; lit_exp[3] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chkb("reset_release_s_ready", s_ready, 1'b1);
    chkb("reset_release_busy", busy, 1'b0);
    @(posedge clk); #1;
    run_job(1'b1, 1, 1'b0, 1'b0, 1'b0, -1);
    run_job(1'b1, 3, 1'b1, 1'b1, 1'b0, -1);
    run_job(1'b1, 2, 1'b0, 1'b0, 1'b0, -1);
    run_job(1'b0, 0, 1'b1, 1'b1, 1'b1, -1);
    run_job(1'b1, 0, 1'b0, 1'b0, 1'b0, 100);
    run_job(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_job(1'b1, 0, 1'b1, 1'b1, 1'b1, -1);
    chk("jobs_done", 32'(jobs_done), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
